// File: rtl/cv32e40s_mpu_otc.sv
// Outstanding-transaction tracker and MPU error responder between core and bus.
// Optional fault capture registers: define CV32E40S_MPU_ERR_CAPTURE_EN.
module cv32e40s_mpu_otc #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W = 32,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_trans_valid_i,
  output logic              core_trans_ready_o,
  input  logic [ADDR_W-1:0] core_trans_addr_i,
  input  logic              core_trans_we_i,
  input  logic              pma_err_i,
  input  logic              pmp_err_i,
  input  logic              core_mpu_err_wait_i,
  output logic              bus_trans_valid_o,
  input  logic              bus_trans_ready_i,
  input  logic              bus_resp_valid_i,
  output logic              core_resp_valid_o,
  output logic [1:0]        core_resp_status_o,
  output logic              core_mpu_err_o,
  output logic [CW-1:0]     outstanding_o
`ifdef CV32E40S_MPU_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              err_we_o,
  output logic              err_capture_valid_o,
  input  logic              err_clear_i
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_we_q;
  logic          mpu_err;
  logic          acc;
  logic          full;
  logic          fault_acc;
  logic          bus_valid;
  logic          ready;

  assign mpu_err   = pma_err_i | pmp_err_i;
  assign full      = (cnt_q == CNT_MAX) & ~bus_resp_valid_i;
  assign fault_acc = (state_q == IDLE) & core_trans_valid_i & mpu_err;

  // Faulting requests are always accepted (never forwarded), even when full.
  always_comb begin
    bus_valid = 1'b0;
    ready     = 1'b0;
    if (state_q == IDLE && core_trans_valid_i) begin
      if (mpu_err) begin
        ready = 1'b1;
      end else begin
        bus_valid = ~full;
        ready     = bus_trans_ready_i & ~full;
      end
    end
  end

  assign acc = bus_valid & bus_trans_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (acc && !bus_resp_valid_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (bus_resp_valid_i && !acc && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_we_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (fault_acc && core_mpu_err_wait_i) begin
            err_we_q <= core_trans_we_i;
            state_q  <= (cnt_d == '0) ? RESP : WAIT;
          end
        end
        WAIT:    if (cnt_d == '0) state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign core_trans_ready_o = rst_n & ready;
  assign bus_trans_valid_o  = rst_n & bus_valid;
  assign core_resp_valid_o  = rst_n & (bus_resp_valid_i | (state_q == RESP));
  assign core_resp_status_o = (state_q == RESP) ? (err_we_q ? 2'b10 : 2'b01) : 2'b00;
  assign core_mpu_err_o     = mpu_err;
  assign outstanding_o      = cnt_q;

`ifdef CV32E40S_MPU_ERR_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_o          <= '0;
      err_we_o            <= 1'b0;
      err_capture_valid_o <= 1'b0;
    end else if (fault_acc && (!err_capture_valid_o || err_clear_i)) begin
      err_addr_o          <= core_trans_addr_i;
      err_we_o            <= core_trans_we_i;
      err_capture_valid_o <= 1'b1;
    end else if (err_clear_i) begin
      err_capture_valid_o <= 1'b0;
    end
  end
`else
  logic unused_addr;
  assign unused_addr = ^core_trans_addr_i;
`endif

  resp_without_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) bus_resp_valid_i |-> (cnt_q != '0));

  mpu_resp_overlap: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == RESP) |-> (cnt_q == '0 && !bus_resp_valid_i));

endmodule

// File: doc/cv32e40s_mpu_otc.md
CV32E40S_MPU_OTC -- requirements
Module: cv32e40s_mpu_otc

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2 (range 1..15), meaning the maximum number of bus transactions in flight.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the width of the transaction address.
REQ-003 SHALL have ports as follows; CW = $clog2(MAX_OUTSTANDING+1).
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- core_trans_valid_i  in  1  core request valid.
- core_trans_ready_o  out  1  request accepted.
- core_trans_addr_i  in  ADDR_W  request address.
- core_trans_we_i  in  1  write=1, read=0.
- pma_err_i / pmp_err_i  in  1 each  combinational check results for the current request.
- core_mpu_err_wait_i  in  1  1 = deferred error response; 0 = immediate report only.
- bus_trans_valid_o  out  1  request forwarded to bus.
- bus_trans_ready_i  in  1  bus accepts request.
- bus_resp_valid_i  in  1  bus response returned.
- core_resp_valid_o  out  1  response to core (bus or MPU).
- core_resp_status_o  out  2  00 OK, 01 RE_FAULT, 10 WR_FAULT.
- core_mpu_err_o  out  1  immediate error = pma_err_i | pmp_err_i.
- outstanding_o  out  CW  current in-flight count.

Function
REQ-004 SHALL define mpu_err = pma_err_i | pmp_err_i, and acc = bus_trans_valid_o & bus_trans_ready_i.
REQ-005 SHALL keep the counter cnt_q: +1 on acc only; -1 on bus_resp_valid_i only; unchanged when both occur; outstanding_o = cnt_q.
REQ-006 SHALL saturate cnt_q at 0 on a response with cnt_q==0; this is an illegal stimulus and SHALL be flagged by an assertion.
REQ-007 SHALL assert full when cnt_q==MAX_OUTSTANDING and bus_resp_valid_i==0. While full, bus_trans_valid_o=0 and core_trans_ready_o=0 for error-free requests.
REQ-008 SHALL use FSM states IDLE, WAIT and RESP, with a registered status flag err_we_q.
REQ-009 IDLE, with core_trans_valid_i & !mpu_err: bus_trans_valid_o = !full; core_trans_ready_o = bus_trans_ready_i & !full.
REQ-010 IDLE, with core_trans_valid_i & mpu_err: bus_trans_valid_o=0 and core_trans_ready_o=1 in the same cycle; this applies regardless of full.
- If core_mpu_err_wait_i=1: capture err_we_q=core_trans_we_i, then go to RESP if next-count==0, otherwise go to WAIT.
- If core_mpu_err_wait_i=0: remain in IDLE and produce no MPU response.
REQ-011 WAIT: bus_trans_valid_o=0 and core_trans_ready_o=0; go to RESP in the cycle next-count becomes 0.
REQ-012 RESP, lasting exactly one cycle:
- core_resp_valid_o=1.
- core_resp_status_o = err_we_q ? 10 : 01.
- Block as in WAIT.
- Go to IDLE unconditionally.
REQ-013 core_resp_valid_o SHALL equal bus_resp_valid_i | (state==RESP); status SHALL be 00 outside RESP.
REQ-014 An MPU response SHALL never coincide with a bus response, because cnt_q==0 in RESP; this SHALL be asserted.
REQ-015 Error-free forwarding SHALL be combinational, with zero added latency; the deferred error response SHALL arrive 1 cycle after the last outstanding response, or 1 cycle after the faulting request if none are outstanding.

Reset
REQ-016 On rst_n=0, the block SHALL asynchronously set state=IDLE, cnt_q=0 and err_we_q=0.
REQ-017 During reset, all outputs except core_mpu_err_o SHALL be 0; core_mpu_err_o SHALL remain combinational.
REQ-018 Reset asserted mid-WAIT or mid-RESP SHALL discard the pending error response.

Configuration
REQ-019 When macro CV32E40S_MPU_ERR_CAPTURE_EN is defined, the block SHALL add the following ports:
- err_addr_o  out  ADDR_W.
- err_we_o  out  1.
- err_capture_valid_o  out  1.
- err_clear_i  in  1.
REQ-020 With the macro defined, the first faulting request accepted while err_capture_valid_o==0 SHALL load err_addr_o/err_we_o and set err_capture_valid_o. Later faults SHALL not overwrite the capture. err_clear_i SHALL clear err_capture_valid_o; a simultaneous new fault SHALL win and load. All three capture registers SHALL reset to 0.
REQ-021 Without the macro, these ports and registers SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-022 MAX_OUTSTANDING=2; three back-to-back clean reads with ready=1 and no responses -> first two forwarded, third stalls (ready_o=0), outstanding_o=2.
REQ-023 cnt_q=2, wait=1, faulting write at addr 0x1000 -> ready_o=1, bus_trans_valid_o=0; WAIT until two bus responses; next cycle core_resp_valid_o=1, status=10.
REQ-024 cnt_q=0, faulting read -> RESP next cycle with status=01, then IDLE; outstanding_o stays 0.
REQ-025 wait=0, faulting read -> core_mpu_err_o=1, ready_o=1, no MPU response, state remains IDLE.
REQ-026 cnt_q=1, simultaneous acc and bus_resp_valid_i -> cnt stays 1; rst_n pulse during WAIT -> cnt=0, IDLE, no response issued.
REQ-027 With the macro defined: faults at 0x2000 then 0x3000 -> err_addr_o=0x2000; err_clear_i, then fault at 0x4000 -> err_addr_o=0x4000.
